drum_word_access: RTL and testbench

Host-side word access controller for drum memory lines 7–18.
- Tracks drum angular position (bit time and word time) from the once-per-revolution origin pulse.
- Accepts one word read or write request at a time from a host/maintenance port.
- Waits for the addressed word to rotate under the heads, then serially reads it into a register or drives write gating into the selected line for exactly 29 bit times.
- Sits between the host bus bridge and the line 7–18 memory block; its one-hot write enables and write data are ORed into that line's recirculation input terms.

---
 rtl/drum_word_access.sv | 138 +++++++++++++
 tb/tb_drum_word_access.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_word_access.sv
// rtl/drum_word_access.sv - host word read/write controller for drum lines 7..18
module drum_word_access #(
    parameter int WORD_BITS = 29,
    parameter int WORDS     = 108
) (
    input  logic                 CLOCK,
    input  logic                 rst_n,
    input  logic                 ORIGIN,
    input  logic                 req,
    input  logic                 we,
    input  logic [4:0]           line,
    input  logic [6:0]           word,
    input  logic [WORD_BITS-1:0] wdata,
    output logic                 ack,
    output logic                 err,
    output logic [WORD_BITS-1:0] rdata,
    output logic                 busy,
    output logic                 locked,
    input  logic [11:0]          RD_BITS,
    output logic [11:0]          WR_EN,
    output logic                 WR_BIT
);

    localparam logic [4:0] LAST_BIT  = 5'(WORD_BITS - 1);
    localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);
    localparam logic [4:0] LINE_LO   = 5'd7;
    localparam logic [4:0] LINE_HI   = 5'd18;

    typedef enum logic [2:0] {IDLE, CHECK, WAIT, XFER, DONE} state_t;

    state_t state, state_nx;

    logic [4:0]           bc;
    logic [6:0]           wc;
    logic [4:0]           cp_bc;
    logic [6:0]           cp_wc;
    logic                 resync;
    logic                 match;
    logic                 xfer_bit;
    logic                 accept;
    logic                 bad_addr;
    logic                 we_r;
    logic                 err_r;
    logic [4:0]           line_r;
    logic [6:0]           word_r;
    logic [WORD_BITS-1:0] wdata_r;
    logic [3:0]           sel;

    // ORIGIN overrides the counters so the current cycle is always position (0,0)
    assign cp_bc    = ORIGIN ? 5'd0 : bc;
    assign cp_wc    = ORIGIN ? 7'd0 : wc;
    assign resync   = ORIGIN && locked && ((bc != 5'd0) || (wc != 7'd0));
    assign match    = (cp_bc == 5'd0) && (cp_wc == word_r);
    assign accept   = (state == IDLE) && req && locked;
    assign bad_addr = (line_r < LINE_LO) || (line_r > LINE_HI) || (word_r > LAST_WORD);
    assign sel      = 4'(line_r - LINE_LO);
    assign xfer_bit = ((state == WAIT) && match) || ((state == XFER) && !resync);

    always_ff @(posedge CLOCK) begin
        if (!rst_n) begin
            bc     <= 5'd0;
            wc     <= 7'd0;
            locked <= 1'b0;
        end else begin
            if (ORIGIN)
                locked <= 1'b1;
            if (cp_bc == LAST_BIT) begin
                bc <= 5'd0;
                wc <= (cp_wc == LAST_WORD) ? 7'd0 : cp_wc + 7'd1;
            end else begin
                bc <= cp_bc + 5'd1;
                wc <= cp_wc;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CHECK;
            CHECK:   state_nx = bad_addr ? DONE : WAIT;
            WAIT:    if (match) state_nx = XFER;
            XFER:    if (resync || (cp_bc == LAST_BIT)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            line_r  <= 5'd0;
            word_r  <= 7'd0;
            wdata_r <= '0;
            rdata   <= '0;
        end else begin
            if (accept) begin
                we_r    <= we;
                line_r  <= line;
                word_r  <= word;
                wdata_r <= wdata;
                err_r   <= 1'b0;
            end
            if ((state == CHECK) && bad_addr)
                err_r <= 1'b1;
            if ((state == XFER) && resync)
                err_r <= 1'b1;
            if (xfer_bit && !we_r)
                rdata[cp_bc] <= RD_BITS[sel];
        end
    end

    // Write gating is combinational so it tracks the bit under the heads in the same cycle
    always_comb begin
        ack    = 1'b0;
        err    = 1'b0;
        busy   = (state != IDLE);
        WR_EN  = 12'd0;
        WR_BIT = 1'b0;
        if (state == DONE) begin
            ack = 1'b1;
            err = err_r;
        end
        if (xfer_bit && we_r) begin
            WR_EN  = 12'd1 << sel;
            WR_BIT = wdata_r[cp_bc];
        end
    end

endmodule

// File: tb/tb_drum_word_access.sv
// tb/tb_drum_word_access.sv - randomized directed bench with a drum/word reference model
module tb_drum_word_access;

    localparam int NB  = 29;
    localparam int NW  = 108;
    localparam int REV = NB * NW;

    logic        CLOCK;
    logic        rst_n;
    logic        ORIGIN;
    logic        req;
    logic        we;
    logic [4:0]  line;
    logic [6:0]  word;
    logic [28:0] wdata;
    logic        ack;
    logic        err;
    logic [28:0] rdata;
    logic        busy;
    logic        locked;
    logic [11:0] RD_BITS;
    logic [11:0] WR_EN;
    logic        WR_BIT;

    int total = 0;
    int bad   = 0;

    bit          drum [12][REV];
    logic [28:0] mem  [12][NW];
    int          pos  = 0;
    bit          spin = 0;
    bit          kick = 0;

    drum_word_access dut (
        .CLOCK(CLOCK), .rst_n(rst_n), .ORIGIN(ORIGIN), .req(req), .we(we),
        .line(line), .word(word), .wdata(wdata), .ack(ack), .err(err),
        .rdata(rdata), .busy(busy), .locked(locked), .RD_BITS(RD_BITS),
        .WR_EN(WR_EN), .WR_BIT(WR_BIT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Rotating drum: position advances once per bit time, ORIGIN at position 0
    initial begin
        ORIGIN  = 1'b0;
        RD_BITS = 12'd0;
        forever begin
            @(posedge CLOCK);
            #1;
            if (spin) begin
                if (kick || pos == REV - 1) pos = 0;
                else pos = pos + 1;
                kick   = 0;
                ORIGIN = (pos == 0);
            end else begin
                ORIGIN = 1'b0;
            end
            for (int l = 0; l < 12; l++) RD_BITS[l] = drum[l][pos];
        end
    end

    initial begin
        forever begin
            @(negedge CLOCK);
            for (int l = 0; l < 12; l++)
                if (WR_EN[l]) drum[l][pos] = WR_BIT;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [28:0] drum_word(input int l, input int w);
        logic [28:0] r;
        for (int b = 0; b < NB; b++) r[b] = drum[l][w * NB + b];
        return r;
    endfunction

    function automatic logic [28:0] merge(input logic [28:0] old, input logic [28:0] nw, input int k);
        logic [28:0] mask;
        mask = 29'((64'd1 << k) - 64'd1);
        return (old & ~mask) | (nw & mask);
    endfunction

    task automatic issue(input logic w, input logic [4:0] l, input logic [6:0] wd, input logic [28:0] d);
        @(negedge CLOCK);
        we = w; line = l; word = wd; wdata = d; req = 1'b1;
    endtask

    task automatic finish_txn(input logic w, input logic [4:0] l, input logic [6:0] wd,
                              input logic [28:0] d, input bit bad_addr, input string tag);
        int n, lat, p2, wcnt, first_pos, exp_lat, li, wi;
        logic [28:0] bits;
        bit onehot_ok, got_ack;
        li = int'(l) - 7;
        wi = int'(wd);
        n = 0;
        while (!busy && n < 4000) begin @(negedge CLOCK); n++; end
        check({tag, "_accept"}, busy, 1);
        lat = 1; wcnt = 0; onehot_ok = 1; bits = '0; first_pos = -1; got_ack = 0; p2 = 0;
        while (lat < 4000) begin
            if (lat == 2) p2 = pos;
            if (WR_EN != 12'd0) begin
                if (wcnt == 0) first_pos = pos;
                if (WR_EN !== (12'd1 << li)) onehot_ok = 0;
                if (wcnt < NB) bits[wcnt] = WR_BIT;
                wcnt++;
            end
            if (ack) begin got_ack = 1; break; end
            @(negedge CLOCK);
            lat++;
        end
        req = 1'b0;
        check({tag, "_ack"}, got_ack, 1);
        if (bad_addr) begin
            check({tag, "_lat"}, lat, 2);
            check({tag, "_err"}, err, 1);
            check({tag, "_wrcycles"}, wcnt, 0);
        end else begin
            exp_lat = 2 + ((wi * NB - p2 + REV) % REV) + NB;
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_err"}, err, 0);
            if (w) begin
                check({tag, "_wrcycles"}, wcnt, NB);
                check({tag, "_wrstart"}, first_pos, wi * NB);
                check({tag, "_onehot"}, onehot_ok, 1);
                check({tag, "_wrbits"}, bits, d);
                mem[li][wi] = d;
                check({tag, "_drum"}, drum_word(li, wi), mem[li][wi]);
            end else begin
                check({tag, "_wrcycles"}, wcnt, 0);
                check({tag, "_rdata"}, rdata, mem[li][wi]);
            end
        end
    endtask

    initial begin
        logic        w;
        logic [4:0]  l;
        logic [6:0]  wd;
        logic [28:0] d;
        bit          seen;
        int          k, n;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; line = 5'd0; word = 7'd0; wdata = '0;
        for (int li = 0; li < 12; li++)
            for (int wi = 0; wi < NW; wi++) begin
                mem[li][wi] = 29'($urandom);
                for (int b = 0; b < NB; b++) drum[li][wi * NB + b] = mem[li][wi][b];
            end

        repeat (3) @(negedge CLOCK);
        check("rst_flags", {ack, err, busy, locked, WR_BIT}, 5'b0);
        check("rst_wren", WR_EN, 12'd0);
        check("rst_rdata", rdata, 29'd0);
        rst_n = 1'b1;

        // No ORIGIN yet: the request must stall
        issue(1'b0, 5'd7, 7'd3, 29'd0);
        seen = 0;
        repeat (20) begin @(negedge CLOCK); if (busy || locked) seen = 1; end
        check("unlocked_stall", seen, 0);
        pos = REV - 1;
        spin = 1;
        @(negedge CLOCK);
        check("origin_seen", ORIGIN, 1);
        check("locked_at_origin", locked, 0);
        @(negedge CLOCK);
        check("locked_after", locked, 1);
        check("pos_after_origin", {dut.wc, dut.bc}, {7'd0, 5'd1});
        finish_txn(1'b0, 5'd7, 7'd3, 29'd0, 0, "first_read");

        issue(1'b1, 5'd12, 7'd5, 29'h1555_5555);
        finish_txn(1'b1, 5'd12, 7'd5, 29'h1555_5555, 0, "wr12_5");

        mem[11][107] = 29'h0ABC_DEF1;
        for (int b = 0; b < NB; b++) drum[11][107 * NB + b] = mem[11][107][b];
        issue(1'b0, 5'd18, 7'd107, 29'd0);
        finish_txn(1'b0, 5'd18, 7'd107, 29'd0, 0, "rd18_107");

        issue(1'b1, 5'd19, 7'd4, 29'h1FFF_FFFF);
        finish_txn(1'b1, 5'd19, 7'd4, 29'h1FFF_FFFF, 1, "bad_line19");
        issue(1'b0, 5'd9, 7'd108, 29'd0);
        finish_txn(1'b0, 5'd9, 7'd108, 29'd0, 1, "bad_word108");
        issue(1'b1, 5'd6, 7'd0, 29'h1);
        finish_txn(1'b1, 5'd6, 7'd0, 29'h1, 1, "bad_line6");

        for (int i = 0; i < 4; i++) begin
            l  = 5'(7 + $urandom_range(0, 11));
            wd = 7'($urandom_range(0, 107));
            d  = 29'($urandom);
            issue(1'b1, l, wd, d);
            finish_txn(1'b1, l, wd, d, 0, "rand_wr");
            w = 1'($urandom_range(0, 1));
            if (w) l = 5'(7 + $urandom_range(0, 11));
            issue(1'b0, l, wd, 29'd0);
            finish_txn(1'b0, l, wd, 29'd0, 0, "rand_rd");
        end

        // Early ORIGIN during bit 10 of a write aborts it
        wd = 7'($urandom_range(0, 107));
        d  = 29'($urandom);
        issue(1'b1, 5'd9, wd, d);
        k = 0; n = 0;
        while (k < 10 && n < 4000) begin @(negedge CLOCK); n++; if (WR_EN != 12'd0) k++; end
        check("abort_reach_bit10", k, 10);
        kick = 1;
        @(negedge CLOCK);
        check("abort_origin", ORIGIN, 1);
        check("abort_wren", WR_EN, 12'd0);
        @(negedge CLOCK);
        check("abort_ack_err", {ack, err}, 2'b11);
        check("abort_pos", {dut.wc, dut.bc}, {7'd0, 5'd1});
        req = 1'b0;
        mem[2][wd] = merge(mem[2][wd], d, 10);
        issue(1'b0, 5'd9, wd, 29'd0);
        finish_txn(1'b0, 5'd9, wd, 29'd0, 0, "abort_readback");

        // Reset while bit 10 of a write is on the heads
        wd = 7'($urandom_range(0, 107));
        d  = 29'($urandom);
        issue(1'b1, 5'd15, wd, d);
        k = 0; n = 0;
        while (k < 11 && n < 4000) begin @(negedge CLOCK); n++; if (WR_EN != 12'd0) k++; end
        check("rst_reach_bit10", k, 11);
        rst_n = 1'b0;
        @(negedge CLOCK);
        check("midrst_wren", WR_EN, 12'd0);
        check("midrst_busy_lock", {busy, locked, ack}, 3'b000);
        rst_n = 1'b1;
        req = 1'b0;
        mem[8][wd] = merge(mem[8][wd], d, 11);
        seen = 0; n = 0;
        while (!locked && n < 4000) begin @(negedge CLOCK); n++; if (ack) seen = 1; end
        check("midrst_relock", locked, 1);
        check("midrst_no_ack", seen, 0);
        issue(1'b0, 5'd15, wd, 29'd0);
        finish_txn(1'b0, 5'd15, wd, 29'd0, 0, "midrst_readback");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
